// File: rtl/nl_pkg.sv
// Shared op codes, FSM state encoding and default widths for the NL command sequencer.
package nl_pkg;

  localparam int NL_DW = 32;
  localparam int NL_AW = 17;

  localparam logic [1:0] OP_ILL   = 2'b00;
  localparam logic [1:0] OP_PRED  = 2'b01;
  localparam logic [1:0] OP_NEWLM = 2'b10;
  localparam logic [1:0] OP_UPD   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4
  } nl_state_e;

  function automatic logic op_legal(input logic [1:0] op);
    return op != OP_ILL;
  endfunction

endpackage

// File: rtl/nl_watchdog.sv
// Saturating up-counter with clear/enable; flags when the count is about to reach TIMEOUT.
module nl_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d, cnt_next;

  always_comb begin
    cnt_next = (cnt_q == TMAX) ? cnt_q : cnt_q + CW'(1);
    cnt_d    = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_next;
    end
  end

  // Flag in the cycle whose increment lands on TIMEOUT, so exactly TIMEOUT enabled cycles elapse.
  assign expired = enable && !clear && (cnt_next == TMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nl_cmd_sequencer.sv
// Command/response front-end that launches one NL core operation at a time and waits for its done.
//   state | meaning
//   IDLE  | ready for a command
//   ISSUE | one-cycle init pulse to the core
//   WAIT  | waiting for matching done or watchdog expiry
//   CAPT  | core results final, capture them
//   RESP  | response held until rsp_ready
module nl_cmd_sequencer
  import nl_pkg::*;
#(
  parameter int DW      = NL_DW,
  parameter int AW      = NL_AW,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [6*DW-1:0] cmd_dw,
  input  logic [3*AW-1:0] cmd_aw,
  output logic            nl_init_predict,
  output logic            nl_init_newlm,
  output logic            nl_init_update,
  output logic [6*DW-1:0] nl_dw,
  output logic [3*AW-1:0] nl_aw,
  input  logic            nl_done_predict,
  input  logic            nl_done_newlm,
  input  logic            nl_done_update,
  input  logic [6*DW-1:0] nl_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [1:0]      rsp_op,
  output logic            rsp_err,
  output logic [6*DW-1:0] rsp_data
);

  nl_state_e       state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [6*DW-1:0] nl_dw_q, nl_dw_d;
  logic [3*AW-1:0] nl_aw_q, nl_aw_d;
  logic [1:0]      rsp_op_q, rsp_op_d;
  logic            rsp_err_q, rsp_err_d;
  logic [6*DW-1:0] rsp_data_q, rsp_data_d;
  logic            accept, done_match, wd_clear, wd_enable, wd_expired;

  nl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    done_match = 1'b0;
    case (op_q)
      OP_PRED:  done_match = nl_done_predict;
      OP_NEWLM: done_match = nl_done_newlm;
      OP_UPD:   done_match = nl_done_update;
      default:  done_match = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    nl_dw_d    = nl_dw_q;
    nl_aw_d    = nl_aw_q;
    rsp_op_d   = rsp_op_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_legal(cmd_op)) begin
            op_d    = cmd_op;
            nl_dw_d = cmd_dw;
            nl_aw_d = cmd_aw;
            state_d = ST_ISSUE;
          end else begin
            rsp_op_d   = OP_ILL;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        wd_clear = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        wd_enable = 1'b1;
        // A matching done takes priority over a simultaneous expiry.
        if (done_match) begin
          state_d = ST_CAPT;
        end else if (wd_expired) begin
          rsp_op_d   = op_q;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_CAPT: begin
        rsp_op_d   = op_q;
        rsp_err_d  = 1'b0;
        rsp_data_d = nl_result;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ILL;
      nl_dw_q    <= '0;
      nl_aw_q    <= '0;
      rsp_op_q   <= OP_ILL;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      nl_dw_q    <= nl_dw_d;
      nl_aw_q    <= nl_aw_d;
      rsp_op_q   <= rsp_op_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign nl_init_predict = (state_q == ST_ISSUE) && (op_q == OP_PRED);
  assign nl_init_newlm   = (state_q == ST_ISSUE) && (op_q == OP_NEWLM);
  assign nl_init_update  = (state_q == ST_ISSUE) && (op_q == OP_UPD);
  assign nl_dw           = nl_dw_q;
  assign nl_aw           = nl_aw_q;
  assign rsp_valid       = (state_q == ST_RESP);
  assign rsp_op          = rsp_op_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_data        = rsp_data_q;

endmodule

// File: tb/tb_nl_cmd_sequencer.sv
// Scoreboard bench for nl_cmd_sequencer with a hand-driven stub core.
module tb_nl_cmd_sequencer;

  localparam int DW = 32;
  localparam int AW = 17;
  localparam int TO = 64;
  localparam int W6 = 6 * DW;
  localparam int W3 = 3 * AW;

  typedef struct packed {
    logic [1:0]    op;
    logic          err;
    logic [W6-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [W6-1:0] cmd_dw = '0;
  logic [W3-1:0] cmd_aw = '0;
  logic          nl_init_predict, nl_init_newlm, nl_init_update;
  logic [W6-1:0] nl_dw;
  logic [W3-1:0] nl_aw;
  logic          nl_done_predict = 1'b0;
  logic          nl_done_newlm = 1'b0;
  logic          nl_done_update = 1'b0;
  logic [W6-1:0] nl_result = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [1:0]    rsp_op;
  logic          rsp_err;
  logic [W6-1:0] rsp_data;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pred = 0, n_newlm = 0, n_upd = 0;
  rsp_t exp_q[$];

  nl_cmd_sequencer #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_dw          (cmd_dw),
    .cmd_aw          (cmd_aw),
    .nl_init_predict (nl_init_predict),
    .nl_init_newlm   (nl_init_newlm),
    .nl_init_update  (nl_init_update),
    .nl_dw           (nl_dw),
    .nl_aw           (nl_aw),
    .nl_done_predict (nl_done_predict),
    .nl_done_newlm   (nl_done_newlm),
    .nl_done_update  (nl_done_update),
    .nl_result       (nl_result),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_op          (rsp_op),
    .rsp_err         (rsp_err),
    .rsp_data        (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W6-1:0] words_1_to_6();
    logic [W6-1:0] v;
    for (int i = 0; i < 6; i++) v[i*DW +: DW] = DW'(i + 1);
    return v;
  endfunction

  // Pulse-width counting and response scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    rsp_t e;
    if (nl_init_predict) n_pred++;
    if (nl_init_newlm)   n_newlm++;
    if (nl_init_update)  n_upd++;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 256'(rsp_valid), 256'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_op", 256'(rsp_op), 256'(e.op));
        check_eq("rsp_err", 256'(rsp_err), 256'(e.err));
        check_eq("rsp_data", 256'(rsp_data), 256'(e.data));
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [W6-1:0] dw, input logic [W3-1:0] aw);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dw    = dw;
    cmd_aw    = aw;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    check_eq("cmd_ready_seen", 256'(cmd_ready), 256'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_dw    = {6{$urandom}};
    cmd_aw    = W3'({$urandom, $urandom});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [W6-1:0] dw_a, res;
    logic [W3-1:0] aw_a;
    int n, seen;

    res  = words_1_to_6();
    dw_a = {6{32'hA5C3_0F11}};
    aw_a = W3'(64'h1_2345_6789_ABCD);

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", 256'(cmd_ready), 256'(0));
    check_eq("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    check_eq("rst_nl_dw", 256'(nl_dw), 256'(0));
    check_eq("rst_nl_aw", 256'(nl_aw), 256'(0));
    check_eq("rst_rsp_data", 256'(rsp_data), 256'(0));
    check_eq("rst_init", 256'({nl_init_predict, nl_init_newlm, nl_init_update}), 256'(0));
    rst = 1'b0;
    #1;
    check_eq("idle_cmd_ready", 256'(cmd_ready), 256'(1));

    // Predict: done 20 cycles after init; results only final after the done cycle.
    exp_q.push_back('{op: 2'b01, err: 1'b0, data: res});
    send_cmd(2'b01, dw_a, aw_a);
    check_eq("pred_init", 256'({nl_init_predict, nl_init_newlm, nl_init_update}), 256'(3'b100));
    check_eq("pred_nl_dw", 256'(nl_dw), 256'(dw_a));
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) break;
      if (n == 10) begin
        check_eq("pred_dw_hold", 256'(nl_dw), 256'(dw_a));
        check_eq("pred_aw_hold", 256'(nl_aw), 256'(aw_a));
      end
      nl_done_predict = (n == 20);
      nl_result       = (n > 20) ? res : {6{32'hDEAD_BEEF}};
    end
    check_eq("pred_latency", 256'(n), 256'(22));
    @(posedge clk); #1;
    check_eq("pred_rsp_cleared", 256'(rsp_valid), 256'(0));
    check_eq("pred_back_idle", 256'(cmd_ready), 256'(1));

    // Illegal op: immediate error response, no init pulse.
    exp_q.push_back('{op: 2'b00, err: 1'b1, data: '0});
    send_cmd(2'b00, dw_a, aw_a);
    check_eq("ill_rsp_next", 256'(rsp_valid), 256'(1));
    check_eq("ill_no_init", 256'({nl_init_predict, nl_init_newlm, nl_init_update}), 256'(0));
    @(posedge clk); #1;

    // Update with a silent core: timeout after TO wait cycles.
    exp_q.push_back('{op: 2'b11, err: 1'b1, data: '0});
    send_cmd(2'b11, dw_a, aw_a);
    check_eq("upd_init", 256'(nl_init_update), 256'(1));
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) break;
    end
    check_eq("upd_timeout_lat", 256'(n), 256'(TO + 1));
    @(posedge clk); #1;

    // Newlm: a non-matching update done is ignored, newlm done at cycle 10 completes.
    exp_q.push_back('{op: 2'b10, err: 1'b0, data: ~res});
    send_cmd(2'b10, dw_a, aw_a);
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) break;
      nl_done_update = (n == 5);
      nl_done_newlm  = (n == 10);
      nl_result      = ~res;
    end
    check_eq("newlm_latency", 256'(n), 256'(12));
    @(posedge clk); #1;

    // Backpressure: response held 5 cycles, a pending command waits for the handshake.
    rsp_ready = 1'b0;
    exp_q.push_back('{op: 2'b01, err: 1'b0, data: res});
    send_cmd(2'b01, dw_a, aw_a);
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) break;
      nl_done_predict = (n == 3);
      nl_result       = res;
    end
    check_eq("bp_latency", 256'(n), 256'(5));
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_valid", 256'(rsp_valid), 256'(1));
      check_eq("bp_hold_data", 256'(rsp_data), 256'(res));
      check_eq("bp_hold_op", 256'({rsp_op, rsp_err}), 256'(3'b010));
      check_eq("bp_cmd_ready", 256'(cmd_ready), 256'(0));
    end
    exp_q.push_back('{op: 2'b00, err: 1'b1, data: '0});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_after_hs_valid", 256'(rsp_valid), 256'(0));
    check_eq("bp_after_hs_ready", 256'(cmd_ready), 256'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("bp_second_rsp", 256'(rsp_valid), 256'(1));
    check_eq("bp_second_err", 256'(rsp_err), 256'(1));
    @(posedge clk); #1;

    // Reset while waiting: everything returns to reset values, late done is ignored.
    send_cmd(2'b10, dw_a, aw_a);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_ready", 256'(cmd_ready), 256'(0));
    check_eq("mid_rst_valid", 256'(rsp_valid), 256'(0));
    check_eq("mid_rst_nl_dw", 256'(nl_dw), 256'(0));
    check_eq("mid_rst_nl_aw", 256'(nl_aw), 256'(0));
    check_eq("mid_rst_init", 256'({nl_init_predict, nl_init_newlm, nl_init_update}), 256'(0));
    rst = 1'b0;
    nl_done_newlm = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      nl_done_newlm = 1'b0;
      if (rsp_valid) seen++;
    end
    check_eq("mid_rst_no_rsp", 256'(seen), 256'(0));
    check_eq("mid_rst_idle", 256'(cmd_ready), 256'(1));

    check_eq("pulses_pred", 256'(n_pred), 256'(2));
    check_eq("pulses_newlm", 256'(n_newlm), 256'(2));
    check_eq("pulses_upd", 256'(n_upd), 256'(1));
    check_eq("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nl_cmd_sequencer.md
NL_CMD_SEQUENCER -- requirements
Module: nl_cmd_sequencer

Interface
REQ-001 Parameter DW, default 32, word width of Q1.12.19 operands/results.
REQ-002 Parameter AW, default 17, width of Q1.1.15 angle operands.
REQ-003 Parameter TIMEOUT, default 1023, max cycles waited for core done.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 cmd_op  in  2  01 predict, 10 newlm, 11 update, 00 illegal.
REQ-010 cmd_dw  in  6*DW  {yk,xk,lky,lkx,rk,vlr}, vlr in LSBs.
REQ-011 cmd_aw  in  3*AW  {phi,xita,alpha}, alpha in LSBs.
REQ-012 nl_init_predict / nl_init_newlm / nl_init_update  out  1 each  one-cycle start pulses to core.
REQ-013 nl_dw  out  6*DW  registered copy of cmd_dw to core.
REQ-014 nl_aw  out  3*AW  registered copy of cmd_aw to core.
REQ-015 nl_done_predict / nl_done_newlm / nl_done_update  in  1 each  core done pulses.
REQ-016 nl_result  in  6*DW  {result_5..result_0} from core.
REQ-017 rsp_valid  out  1  response available.
REQ-018 rsp_ready  in  1  downstream accepts response.
REQ-019 rsp_op  out  2  op of the response.
REQ-020 rsp_err  out  1  1 = illegal op or timeout.
REQ-021 rsp_data  out  6*DW  captured results; zero when rsp_err.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT, CAPT, RESP.
REQ-023 cmd_ready = 1 only in IDLE; accept = cmd_valid & cmd_ready.
REQ-024 IDLE, accept, legal op: latch op, nl_dw, nl_aw -> ISSUE.
REQ-025 IDLE, accept, op 00: rsp_op=00, rsp_err=1, rsp_data=0 -> RESP; no init pulse.
REQ-026 ISSUE (exactly 1 cycle): the matching nl_init_* is high; others low -> WAIT; timeout counter cleared.
REQ-027 nl_dw/nl_aw held constant from ISSUE until return to IDLE; core reads operands mid-run.
REQ-028 WAIT: done pulse matching latched op -> CAPT; non-matching done pulses ignored.
REQ-029 WAIT: counter increments each cycle; when counter reaches TIMEOUT without matching done -> RESP with rsp_err=1, rsp_data=0.
REQ-030 Matching done and timeout in same cycle: done wins (CAPT).
REQ-031 CAPT (1 cycle): core finalises results at end of its done cycle; rsp_data <= nl_result at end of CAPT, rsp_err=0 -> RESP.
REQ-032 Latency: rsp_valid rises 2 cycles after cycle in which matching done is high.
REQ-033 RESP: rsp_valid=1; rsp_op/err/data stable until rsp_valid & rsp_ready, then -> IDLE.
REQ-034 No back-to-back accept: new command accepted earliest the cycle after response handshake.
REQ-035 Counter width = $clog2(TIMEOUT+1); saturates, never wraps.

Reset
REQ-036 On rst: state=IDLE, cmd_ready=0 during rst, all nl_init_*=0, nl_dw=0, nl_aw=0, rsp_valid=0, rsp_op=0, rsp_err=0, rsp_data=0, counter=0.
REQ-037 Reset mid-operation (any state) aborts; no response emitted; core shares rst.

Structure
REQ-038 Package nl_pkg holds op codes (OP_ILL, OP_PRED, OP_NEWLM, OP_UPD), FSM state enum, default DW/AW.
REQ-039 One sub-module nl_watchdog: clear/enable counter with expired flag, parameter TIMEOUT.

Verification
REQ-040 Predict, stub core done 20 cycles after init, nl_result words 1..6 -> one nl_init_predict pulse, rsp_valid 2 cycles after done, rsp_data words 1..6, rsp_err=0, rsp_op=01.
REQ-041 cmd_op=00 -> rsp_valid next cycle, rsp_err=1, rsp_data=0, no nl_init_* pulse.
REQ-042 TIMEOUT=64, update, stub never done -> rsp_valid after 64 WAIT cycles, rsp_err=1, rsp_op=11.
REQ-043 Newlm, stub pulses nl_done_update then nl_done_newlm at cycle 10 -> first ignored, response on newlm done, rsp_op=10.
REQ-044 rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0; accept only after handshake.
REQ-045 rst asserted in WAIT -> next cycle all outputs at reset values; late done pulse produces no response.
